// File: rtl/lock_supervisor.sv
// Attempt-based push-button code lock: buffers CODE_LEN digits, compares, times the unlock window and lockout.
// Define LOCK_SUPERVISOR_TIMEOUT_EN to abandon an entry after ENTRY_TIMEOUT idle cycles.
module lock_supervisor #(
  parameter int unsigned         CODE_LEN       = 5,
  parameter logic [CODE_LEN-1:0] CODE           = 5'b01011,
  parameter int unsigned         MAX_FAILS      = 3,
  parameter int unsigned         UNLOCK_CYCLES  = 500,
  parameter int unsigned         LOCKOUT_CYCLES = 1000,
  parameter int unsigned         ENTRY_TIMEOUT  = 2000
) (
  input  logic       clk,
  input  logic       reset_in,
  input  logic       b0,
  input  logic       b1,
  output logic       unlocked,
  output logic       lockout,
  output logic       fail_pulse,
  output logic [3:0] digit_count,
  output logic [3:0] fail_count,
  output logic [3:0] hex_display
);

  localparam int unsigned MAX_A = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned MAX_T = (MAX_A > ENTRY_TIMEOUT) ? MAX_A : ENTRY_TIMEOUT;
  localparam int unsigned TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    LOCKOUT = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CODE_LEN-1:0] entry_q, entry_d;
  logic [3:0]          digit_cnt_q, digit_cnt_d;
  logic [3:0]          fail_cnt_q, fail_cnt_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                fail_pulse_q, fail_pulse_d;

  logic                press;
  logic                digit;
  logic [CODE_LEN-1:0] entry_shift;
  logic [3:0]          digit_inc;
  logic [3:0]          fail_next;

  // b0 wins a simultaneous press, so the digit is 1 only when b1 is pressed alone
  assign press       = b0 | b1;
  assign digit       = ~b0;
  assign entry_shift = (entry_q << 1) | CODE_LEN'(digit);
  assign digit_inc   = digit_cnt_q + 4'd1;
  assign fail_next   = (fail_cnt_q < 4'(MAX_FAILS)) ? fail_cnt_q + 4'd1 : fail_cnt_q;

  always_comb begin
    state_d      = state_q;
    entry_d      = entry_q;
    digit_cnt_d  = digit_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    timer_d      = timer_q;
    fail_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (press) begin
          entry_d     = entry_shift;
          digit_cnt_d = 4'd1;
          state_d     = (CODE_LEN == 1) ? CHECK : ENTRY;
`ifdef LOCK_SUPERVISOR_TIMEOUT_EN
          timer_d     = TW'(ENTRY_TIMEOUT - 1);
`endif
        end
      end
      ENTRY: begin
        if (press) begin
          entry_d     = entry_shift;
          digit_cnt_d = digit_inc;
          if (digit_inc == 4'(CODE_LEN)) state_d = CHECK;
`ifdef LOCK_SUPERVISOR_TIMEOUT_EN
          timer_d     = TW'(ENTRY_TIMEOUT - 1);
        end else if (timer_q == '0) begin
          state_d     = IDLE;
          entry_d     = '0;
          digit_cnt_d = '0;
        end else begin
          timer_d     = timer_q - TW'(1);
`endif
        end
      end
      CHECK: begin
        entry_d     = '0;
        digit_cnt_d = '0;
        if (entry_q == CODE) begin
          state_d    = OPEN;
          fail_cnt_d = '0;
          timer_d    = TW'(UNLOCK_CYCLES - 1);
        end else begin
          fail_pulse_d = 1'b1;
          fail_cnt_d   = fail_next;
          if (fail_next == 4'(MAX_FAILS)) begin
            state_d = LOCKOUT;
            timer_d = TW'(LOCKOUT_CYCLES - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      OPEN: begin
        if (timer_q == '0) state_d = IDLE;
        else               timer_d = timer_q - TW'(1);
      end
      LOCKOUT: begin
        if (timer_q == '0) begin
          state_d    = IDLE;
          fail_cnt_d = '0;
        end else begin
          timer_d    = timer_q - TW'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        entry_d     = '0;
        digit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q      <= IDLE;
      entry_q      <= '0;
      digit_cnt_q  <= '0;
      fail_cnt_q   <= '0;
      timer_q      <= '0;
      fail_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      digit_cnt_q  <= digit_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      timer_q      <= timer_d;
      fail_pulse_q <= fail_pulse_d;
    end
  end

  assign unlocked    = (state_q == OPEN);
  assign lockout     = (state_q == LOCKOUT);
  assign fail_pulse  = fail_pulse_q;
  assign digit_count = digit_cnt_q;
  assign fail_count  = fail_cnt_q;
  assign hex_display = {1'b0, state_q};

endmodule

// File: tb/tb_lock_supervisor.sv
// Self-checking bench for lock_supervisor: directed scenarios plus randomized attempts against an attempt-level model.
module tb_lock_supervisor;

  localparam int unsigned UNL      = 8;
  localparam int unsigned LKO      = 16;
  localparam int unsigned TMO      = 10;
  localparam int unsigned NFAIL    = 3;
  localparam int          CODE_INT = 11;  // digits 0,1,0,1,1, first press most significant

  logic       clk = 1'b0;
  logic       reset_in, b0, b1;
  logic       unlocked, lockout, fail_pulse;
  logic [3:0] digit_count, fail_count, hex_display;

  int passes   = 0;
  int checks   = 0;
  int exp_fail = 0;

  lock_supervisor #(
    .CODE_LEN      (5),
    .CODE          (5'b01011),
    .MAX_FAILS     (NFAIL),
    .UNLOCK_CYCLES (UNL),
    .LOCKOUT_CYCLES(LKO),
    .ENTRY_TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .reset_in   (reset_in),
    .b0         (b0),
    .b1         (b1),
    .unlocked   (unlocked),
    .lockout    (lockout),
    .fail_pulse (fail_pulse),
    .digit_count(digit_count),
    .fail_count (fail_count),
    .hex_display(hex_display)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives a one-cycle press; returns in the cycle after it was captured.
  task automatic press(input int d, input bit both);
    if (both)        begin b0 = 1'b1; b1 = 1'b1; end
    else if (d != 0) b1 = 1'b1;
    else             b0 = 1'b1;
    @(negedge clk);
    b0 = 1'b0;
    b1 = 1'b0;
  endtask

  // Five digits of val, most significant first; returns in the cycle after the final press.
  task automatic enter(input int val, input int gap, input bit both_first);
    int d;
    for (int i = 0; i < 5; i++) begin
      d = (val >> (4 - i)) & 1;
      press(d, both_first && (i == 0) && (d == 0));
      if (i < 4) idle(gap);
    end
  endtask

  task automatic test_reset;
    reset_in = 1'b1; b0 = 1'b0; b1 = 1'b0;
    idle(3);
    checks++; if (hex_display !== 4'd0) $display("FAIL rst_hex: got %0d want 0", hex_display); else passes++;
    checks++; if (unlocked !== 1'b0) $display("FAIL rst_unl: got %b want 0", unlocked); else passes++;
    checks++; if (lockout !== 1'b0) $display("FAIL rst_lko: got %b want 0", lockout); else passes++;
    checks++; if (fail_pulse !== 1'b0) $display("FAIL rst_fp: got %b want 0", fail_pulse); else passes++;
    checks++; if (digit_count !== 4'd0) $display("FAIL rst_dc: got %0d want 0", digit_count); else passes++;
    checks++; if (fail_count !== 4'd0) $display("FAIL rst_fc: got %0d want 0", fail_count); else passes++;
    reset_in = 1'b0;
    idle(1);
    checks++; if (hex_display !== 4'd0) $display("FAIL rst_idle: got %0d want 0", hex_display); else passes++;
  endtask

  task automatic test_correct;
    int d, first, cnt, hex_bad;
    for (int i = 0; i < 5; i++) begin
      d = (CODE_INT >> (4 - i)) & 1;
      press(d, 1'b0);
      if (i < 4) begin
        checks++; if (digit_count !== 4'(i + 1)) $display("FAIL corr_dc%0d: got %0d want %0d", i, digit_count, i + 1); else passes++;
        checks++; if (hex_display !== 4'd1) $display("FAIL corr_entry%0d: got %0d want 1", i, hex_display); else passes++;
        idle(2);
      end
    end
    checks++; if (hex_display !== 4'd2) $display("FAIL corr_check: got %0d want 2", hex_display); else passes++;
    checks++; if (digit_count !== 4'd5) $display("FAIL corr_dc5: got %0d want 5", digit_count); else passes++;
    checks++; if (unlocked !== 1'b0) $display("FAIL corr_unl_early: got %b want 0", unlocked); else passes++;
    first = -1; cnt = 0; hex_bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (unlocked === 1'b1) begin
        if (first < 0) first = k;
        cnt++;
        if (hex_display !== 4'd3) hex_bad++;
      end
    end
    checks++; if (first != 0) $display("FAIL corr_start: got offset %0d want 0", first); else passes++;
    checks++; if (cnt != int'(UNL)) $display("FAIL corr_len: got %0d want %0d", cnt, UNL); else passes++;
    checks++; if (hex_bad != 0) $display("FAIL corr_hex_open: got %0d bad want 0", hex_bad); else passes++;
    checks++; if (hex_display !== 4'd0) $display("FAIL corr_hex_end: got %0d want 0", hex_display); else passes++;
    checks++; if (fail_count !== 4'd0) $display("FAIL corr_fc: got %0d want 0", fail_count); else passes++;
  endtask

  task automatic test_wrong;
    enter(31, 1, 1'b0);
    checks++; if (hex_display !== 4'd2) $display("FAIL wr_check: got %0d want 2", hex_display); else passes++;
    @(negedge clk);
    exp_fail = 1;
    checks++; if (fail_pulse !== 1'b1) $display("FAIL wr_fp: got %b want 1", fail_pulse); else passes++;
    checks++; if (fail_count !== 4'(exp_fail)) $display("FAIL wr_fc: got %0d want %0d", fail_count, exp_fail); else passes++;
    checks++; if (hex_display !== 4'd0) $display("FAIL wr_idle: got %0d want 0", hex_display); else passes++;
    @(negedge clk);
    checks++; if (fail_pulse !== 1'b0) $display("FAIL wr_fp_end: got %b want 0", fail_pulse); else passes++;
    enter(CODE_INT, 0, 1'b0);
    @(negedge clk);
    exp_fail = 0;
    checks++; if (unlocked !== 1'b1) $display("FAIL wr_reopen: got %b want 1", unlocked); else passes++;
    checks++; if (fail_count !== 4'd0) $display("FAIL wr_fc_clr: got %0d want 0", fail_count); else passes++;
    idle(UNL);
    checks++; if (unlocked !== 1'b0) $display("FAIL wr_close: got %b want 0", unlocked); else passes++;
  endtask

  task automatic test_lockout;
    int v, lk, dc_bad;
    for (int a = 0; a < int'(NFAIL); a++) begin
      do v = int'($urandom_range(0, 31)); while (v == CODE_INT);
      enter(v, 1, 1'b0);
      @(negedge clk);
      exp_fail++;
      checks++; if (fail_pulse !== 1'b1) $display("FAIL lk_fp%0d: got %b want 1", a, fail_pulse); else passes++;
      checks++; if (fail_count !== 4'(exp_fail)) $display("FAIL lk_fc%0d: got %0d want %0d", a, fail_count, exp_fail); else passes++;
      if (a < int'(NFAIL) - 1) idle(1);
    end
    lk = 0; dc_bad = 0;
    for (int k = 0; k < int'(LKO); k++) begin
      if (lockout === 1'b1) lk++;
      if (digit_count !== 4'd0) dc_bad++;
      press(int'($urandom_range(0, 1)), 1'b0);
    end
    exp_fail = 0;
    checks++; if (lk != int'(LKO)) $display("FAIL lk_len: got %0d want %0d", lk, LKO); else passes++;
    checks++; if (dc_bad != 0) $display("FAIL lk_ignore: got %0d nonzero digit_count cycles want 0", dc_bad); else passes++;
    checks++; if (lockout !== 1'b0) $display("FAIL lk_end: got %b want 0", lockout); else passes++;
    checks++; if (hex_display !== 4'd0) $display("FAIL lk_idle: got %0d want 0", hex_display); else passes++;
    checks++; if (fail_count !== 4'd0) $display("FAIL lk_fc_clr: got %0d want 0", fail_count); else passes++;
    press(0, 1'b0);
    checks++; if (digit_count !== 4'd1) $display("FAIL lk_first_press: got %0d want 1", digit_count); else passes++;
    press(1, 1'b0); press(0, 1'b0); press(1, 1'b0); press(1, 1'b0);
    @(negedge clk);
    checks++; if (unlocked !== 1'b1) $display("FAIL lk_unlock: got %b want 1", unlocked); else passes++;
    idle(UNL);
  endtask

  task automatic test_simultaneous;
    enter(CODE_INT, 1, 1'b1);
    @(negedge clk);
    checks++; if (unlocked !== 1'b1) $display("FAIL sim_unlock: got %b want 1", unlocked); else passes++;
    idle(UNL);
    checks++; if (unlocked !== 1'b0) $display("FAIL sim_close: got %b want 0", unlocked); else passes++;
  endtask

  task automatic test_back_to_back;
    enter(CODE_INT, 0, 1'b0);
    checks++; if (hex_display !== 4'd2) $display("FAIL b2b_check: got %0d want 2", hex_display); else passes++;
    @(negedge clk);
    checks++; if (unlocked !== 1'b1) $display("FAIL b2b_unlock: got %b want 1", unlocked); else passes++;
    idle(UNL);
  endtask

  task automatic test_reset_mid;
    enter(0, 1, 1'b0);
    idle(2);
    exp_fail = 1;
    checks++; if (fail_count !== 4'd1) $display("FAIL rm_fc_pre: got %0d want 1", fail_count); else passes++;
    press(0, 1'b0); press(1, 1'b0); press(0, 1'b0);
    checks++; if (digit_count !== 4'd3) $display("FAIL rm_dc_pre: got %0d want 3", digit_count); else passes++;
    reset_in = 1'b1; b1 = 1'b1;
    @(negedge clk);
    reset_in = 1'b0; b1 = 1'b0;
    exp_fail = 0;
    checks++; if (hex_display !== 4'd0) $display("FAIL rm_hex: got %0d want 0", hex_display); else passes++;
    checks++; if (digit_count !== 4'd0) $display("FAIL rm_dc: got %0d want 0", digit_count); else passes++;
    checks++; if (fail_count !== 4'd0) $display("FAIL rm_fc: got %0d want 0", fail_count); else passes++;
    enter(CODE_INT, 0, 1'b0);
    @(negedge clk);
    idle(3);
    checks++; if (unlocked !== 1'b1) $display("FAIL rm_open: got %b want 1", unlocked); else passes++;
    reset_in = 1'b1;
    @(negedge clk);
    reset_in = 1'b0;
    checks++; if (unlocked !== 1'b0) $display("FAIL rm_open_unl: got %b want 0", unlocked); else passes++;
    checks++; if (hex_display !== 4'd0) $display("FAIL rm_open_hex: got %0d want 0", hex_display); else passes++;
    checks++; if (digit_count !== 4'd0) $display("FAIL rm_open_dc: got %0d want 0", digit_count); else passes++;
  endtask

  // Model works per attempt: value from arithmetic on the pressed digits, outcome and fail tally from the rules.
  task automatic test_random(input int n);
    int code, gap, val, d, lk;
    bit both;
    for (int a = 0; a < n; a++) begin
      code = ($urandom_range(0, 1) == 1) ? CODE_INT : int'($urandom_range(0, 31));
      gap  = int'($urandom_range(0, 3));
      both = 1'($urandom_range(0, 1));
      val  = 0;
      for (int i = 0; i < 5; i++) begin
        d = (code >> (4 - i)) & 1;
        press(d, both && (d == 0));
        val = val * 2 + d;
        if (i < 4) begin
          checks++; if (digit_count !== 4'(i + 1)) $display("FAIL rnd%0d_dc%0d: got %0d want %0d", a, i, digit_count, i + 1); else passes++;
          idle(gap);
        end
      end
      checks++; if (hex_display !== 4'd2) $display("FAIL rnd%0d_check: got %0d want 2", a, hex_display); else passes++;
      @(negedge clk);
      if (val == CODE_INT) begin
        exp_fail = 0;
        checks++; if (unlocked !== 1'b1) $display("FAIL rnd%0d_unl: got %b want 1", a, unlocked); else passes++;
        checks++; if (fail_count !== 4'd0) $display("FAIL rnd%0d_fc0: got %0d want 0", a, fail_count); else passes++;
        idle(UNL - 1);
        checks++; if (unlocked !== 1'b1) $display("FAIL rnd%0d_unl_last: got %b want 1", a, unlocked); else passes++;
        idle(1);
        checks++; if (unlocked !== 1'b0) $display("FAIL rnd%0d_unl_end: got %b want 0", a, unlocked); else passes++;
      end else begin
        if (exp_fail < int'(NFAIL)) exp_fail++;
        checks++; if (fail_pulse !== 1'b1) $display("FAIL rnd%0d_fp: got %b want 1", a, fail_pulse); else passes++;
        checks++; if (fail_count !== 4'(exp_fail)) $display("FAIL rnd%0d_fc: got %0d want %0d", a, fail_count, exp_fail); else passes++;
        if (exp_fail == int'(NFAIL)) begin
          lk = 0;
          for (int k = 0; k < int'(LKO); k++) begin
            if (lockout === 1'b1 && digit_count === 4'd0) lk++;
            if ($urandom_range(0, 1) == 1) press(int'($urandom_range(0, 1)), 1'b0);
            else idle(1);
          end
          exp_fail = 0;
          checks++; if (lk != int'(LKO)) $display("FAIL rnd%0d_lk: got %0d want %0d", a, lk, LKO); else passes++;
          checks++; if (lockout !== 1'b0) $display("FAIL rnd%0d_lk_end: got %b want 0", a, lockout); else passes++;
          checks++; if (fail_count !== 4'd0) $display("FAIL rnd%0d_lk_fc: got %0d want 0", a, fail_count); else passes++;
        end else begin
          checks++; if (hex_display !== 4'd0) $display("FAIL rnd%0d_idle: got %0d want 0", a, hex_display); else passes++;
          idle(1);
          checks++; if (fail_pulse !== 1'b0) $display("FAIL rnd%0d_fp_end: got %b want 0", a, fail_pulse); else passes++;
        end
      end
    end
  endtask

  task automatic test_timeout;
    enter(31, 0, 1'b0);
    @(negedge clk);
    if (exp_fail < int'(NFAIL)) exp_fail++;
    if (exp_fail == int'(NFAIL)) begin
      idle(LKO);
      exp_fail = 0;
    end
    press(1, 1'b0);
    press(0, 1'b0);
    idle(TMO - 1);
    checks++; if (hex_display !== 4'd1) $display("FAIL to_still_entry: got %0d want 1", hex_display); else passes++;
    checks++; if (digit_count !== 4'd2) $display("FAIL to_dc_pre: got %0d want 2", digit_count); else passes++;
    idle(1);
`ifdef LOCK_SUPERVISOR_TIMEOUT_EN
    checks++; if (hex_display !== 4'd0) $display("FAIL to_idle: got %0d want 0", hex_display); else passes++;
    checks++; if (digit_count !== 4'd0) $display("FAIL to_dc: got %0d want 0", digit_count); else passes++;
    checks++; if (fail_count !== 4'(exp_fail)) $display("FAIL to_fc: got %0d want %0d", fail_count, exp_fail); else passes++;
    checks++; if (fail_pulse !== 1'b0) $display("FAIL to_fp: got %b want 0", fail_pulse); else passes++;
`else
    checks++; if (hex_display !== 4'd1) $display("FAIL to_wait: got %0d want 1", hex_display); else passes++;
    checks++; if (digit_count !== 4'd2) $display("FAIL to_dc_hold: got %0d want 2", digit_count); else passes++;
    checks++; if (fail_count !== 4'(exp_fail)) $display("FAIL to_fc_hold: got %0d want %0d", fail_count, exp_fail); else passes++;
    reset_in = 1'b1;
    @(negedge clk);
    reset_in = 1'b0;
    exp_fail = 0;
`endif
  endtask

  initial begin
    reset_in = 1'b0; b0 = 1'b0; b1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_correct();
    test_wrong();
    test_lockout();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_random(40);
    test_timeout();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
